// File: rtl/qsys_serial_arbiter.sv
// Two-requester Avalon-MM arbiter in front of one slow serial device.
// Ports: avs_s0_*/avs_s1_* requester slaves, avm_m0_* downstream master,
//   timeout_err sticky abandon flag, grant_id owner of current/last transfer.
module qsys_serial_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [7:0]  avs_s0_address,
    input  logic [31:0] avs_s0_writedata,
    input  logic [3:0]  avs_s0_byteenable,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_waitrequest,
    input  logic [7:0]  avs_s1_address,
    input  logic [31:0] avs_s1_writedata,
    input  logic [3:0]  avs_s1_byteenable,
    input  logic        avs_s1_write,
    input  logic        avs_s1_read,
    output logic [31:0] avs_s1_readdata,
    output logic        avs_s1_waitrequest,
    output logic [7:0]  avm_m0_address,
    output logic [31:0] avm_m0_writedata,
    output logic [3:0]  avm_m0_byteenable,
    output logic        avm_m0_write,
    output logic        avm_m0_read,
    input  logic [31:0] avm_m0_readdata,
    input  logic        avm_m0_waitrequest,
    output logic        timeout_err,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_m_addr;
    logic [31:0] r_m_wdata;
    logic [3:0]  r_m_be;
    logic        r_m_wr;
    logic        r_m_rd;
    logic [31:0] r_s0_rdata;
    logic [31:0] r_s1_rdata;
    logic        r_s0_wait;
    logic        r_s1_wait;
    logic        r_terr;
    logic        r_gid;
    logic [15:0] r_tcnt;
    logic        r_rr;

    logic [7:0]  w_m_addr_nxt;
    logic [31:0] w_m_wdata_nxt;
    logic [3:0]  w_m_be_nxt;
    logic        w_m_wr_nxt;
    logic        w_m_rd_nxt;
    logic [31:0] w_s0_rdata_nxt;
    logic [31:0] w_s1_rdata_nxt;
    logic        w_s0_wait_nxt;
    logic        w_s1_wait_nxt;
    logic        w_terr_nxt;
    logic        w_gid_nxt;
    logic [15:0] w_tcnt_nxt;
    logic        w_rr_nxt;
    logic [31:0] w_resp;

    logic        w_req0;
    logic        w_req1;
    logic        w_tie;
    logic        w_gnt_vld;
    logic        w_sel;
    logic        w_sel_wr;
    logic        w_sel_rd;
    logic [7:0]  w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_be;
    logic        w_ack;
    logic        w_tmo;

    assign w_req0    = avs_s0_write | avs_s0_read;
    assign w_req1    = avs_s1_write | avs_s1_read;
    assign w_tie     = w_req0 & w_req1;
    assign w_gnt_vld = w_req0 | w_req1;

    // r_rr names the requester that wins the next tie.
    always_comb begin
        w_sel = 1'b0;
        unique case (1'b1)
            w_tie:             w_sel = r_rr;
            w_req1 & ~w_req0:  w_sel = 1'b1;
            default:           w_sel = 1'b0;
        endcase
    end

    assign w_sel_wr    = w_sel ? avs_s1_write : avs_s0_write;
    // A simultaneous write+read is carried out as a write only.
    assign w_sel_rd    = w_sel ? (avs_s1_read & ~avs_s1_write)
                               : (avs_s0_read & ~avs_s0_write);
    assign w_sel_addr  = w_sel ? avs_s1_address : avs_s0_address;
    assign w_sel_wdata = w_sel ? avs_s1_writedata : avs_s0_writedata;
    assign w_sel_be    = w_sel ? avs_s1_byteenable : avs_s0_byteenable;

    assign w_ack = (r_state == S_BUSY) & ~avm_m0_waitrequest;
    assign w_tmo = (r_state == S_BUSY) & avm_m0_waitrequest &
                   (r_tcnt == TIMEOUT - 16'd1);

    // State and output registers
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_state    <= S_IDLE;
            r_m_addr   <= 8'h0;
            r_m_wdata  <= 32'h0;
            r_m_be     <= 4'h0;
            r_m_wr     <= 1'b0;
            r_m_rd     <= 1'b0;
            r_s0_rdata <= 32'h0;
            r_s1_rdata <= 32'h0;
            r_s0_wait  <= 1'b1;
            r_s1_wait  <= 1'b1;
            r_terr     <= 1'b0;
            r_gid      <= 1'b0;
            r_tcnt     <= 16'h0;
            r_rr       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_m_addr   <= w_m_addr_nxt;
            r_m_wdata  <= w_m_wdata_nxt;
            r_m_be     <= w_m_be_nxt;
            r_m_wr     <= w_m_wr_nxt;
            r_m_rd     <= w_m_rd_nxt;
            r_s0_rdata <= w_s0_rdata_nxt;
            r_s1_rdata <= w_s1_rdata_nxt;
            r_s0_wait  <= w_s0_wait_nxt;
            r_s1_wait  <= w_s1_wait_nxt;
            r_terr     <= w_terr_nxt;
            r_gid      <= w_gid_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_rr       <= w_rr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_gnt_vld) w_state_nxt = S_BUSY;
            S_BUSY: if (w_ack || w_tmo) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        w_m_addr_nxt   = r_m_addr;
        w_m_wdata_nxt  = r_m_wdata;
        w_m_be_nxt     = r_m_be;
        w_m_wr_nxt     = r_m_wr;
        w_m_rd_nxt     = r_m_rd;
        w_s0_rdata_nxt = r_s0_rdata;
        w_s1_rdata_nxt = r_s1_rdata;
        w_s0_wait_nxt  = 1'b1;
        w_s1_wait_nxt  = 1'b1;
        w_terr_nxt     = r_terr;
        w_gid_nxt      = r_gid;
        w_tcnt_nxt     = r_tcnt;
        w_rr_nxt       = r_rr;
        w_resp         = 32'h0;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_m_addr_nxt  = w_sel_addr;
                    w_m_wdata_nxt = w_sel_wdata;
                    w_m_be_nxt    = w_sel_be;
                    w_m_wr_nxt    = w_sel_wr;
                    w_m_rd_nxt    = w_sel_rd;
                    w_gid_nxt     = w_sel;
                    w_tcnt_nxt    = 16'h0;
                    // Only a contested grant moves the tie pointer.
                    if (w_tie) w_rr_nxt = ~w_sel;
                end
            end
            S_BUSY: begin
                w_tcnt_nxt = r_tcnt + 16'd1;
                if (w_ack || w_tmo) begin
                    w_m_wr_nxt = 1'b0;
                    w_m_rd_nxt = 1'b0;
                    if (w_ack) begin
                        w_resp = r_m_rd ? avm_m0_readdata : 32'h0;
                    end else begin
                        w_resp     = 32'hDEAD_0000;
                        w_terr_nxt = 1'b1;
                    end
                    if (r_gid) begin
                        w_s1_wait_nxt  = 1'b0;
                        w_s1_rdata_nxt = w_resp;
                    end else begin
                        w_s0_wait_nxt  = 1'b0;
                        w_s0_rdata_nxt = w_resp;
                    end
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    assign avm_m0_address     = r_m_addr;
    assign avm_m0_writedata   = r_m_wdata;
    assign avm_m0_byteenable  = r_m_be;
    assign avm_m0_write       = r_m_wr;
    assign avm_m0_read        = r_m_rd;
    assign avs_s0_readdata    = r_s0_rdata;
    assign avs_s1_readdata    = r_s1_rdata;
    assign avs_s0_waitrequest = r_s0_wait;
    assign avs_s1_waitrequest = r_s1_wait;
    assign timeout_err        = r_terr;
    assign grant_id           = r_gid;

endmodule

// File: tb/tb_qsys_serial_arbiter.sv
// Randomized self-checking bench for qsys_serial_arbiter.
// Downstream device is a latency-programmable responder with a memory.
module tb_qsys_serial_arbiter;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s0_addr = '0, s1_addr = '0;
    logic [31:0] s0_wd = '0, s1_wd = '0;
    logic [3:0]  s0_be = '0, s1_be = '0;
    logic        s0_wr = 1'b0, s0_rd = 1'b0;
    logic        s1_wr = 1'b0, s1_rd = 1'b0;
    logic [31:0] s0_rdata, s1_rdata;
    logic        s0_wait, s1_wait;
    logic [7:0]  m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic        m_wr, m_rd;
    logic [31:0] m_rdata;
    logic        m_wait;
    logic        terr, gid;

    int checks = 0;
    int errors = 0;

    // ds_lat: cycles of waitrequest before accepting; -1 never accepts
    int          ds_lat = 0;
    int          ds_cnt = 0;
    logic [31:0] ds_mem [256];
    xfer_t       mon_log [$];
    int          wr_cyc = 0;
    int          rd_cyc = 0;
    bit          proto_bad = 1'b0;

    always #5 clk = ~clk;

    qsys_serial_arbiter #(.TIMEOUT(16'd16)) dut (
        .csi_MCLK_clk      (clk),
        .rsi_MRST_reset    (rst),
        .avs_s0_address    (s0_addr),
        .avs_s0_writedata  (s0_wd),
        .avs_s0_byteenable (s0_be),
        .avs_s0_write      (s0_wr),
        .avs_s0_read       (s0_rd),
        .avs_s0_readdata   (s0_rdata),
        .avs_s0_waitrequest(s0_wait),
        .avs_s1_address    (s1_addr),
        .avs_s1_writedata  (s1_wd),
        .avs_s1_byteenable (s1_be),
        .avs_s1_write      (s1_wr),
        .avs_s1_read       (s1_rd),
        .avs_s1_readdata   (s1_rdata),
        .avs_s1_waitrequest(s1_wait),
        .avm_m0_address    (m_addr),
        .avm_m0_writedata  (m_wd),
        .avm_m0_byteenable (m_be),
        .avm_m0_write      (m_wr),
        .avm_m0_read       (m_rd),
        .avm_m0_readdata   (m_rdata),
        .avm_m0_waitrequest(m_wait),
        .timeout_err       (terr),
        .grant_id          (gid)
    );

    assign m_wait  = !((m_wr || m_rd) && ds_lat >= 0 && ds_cnt >= ds_lat);
    assign m_rdata = ds_mem[m_addr];

    always @(posedge clk) begin
        if ((m_wr || m_rd) && m_wait) ds_cnt <= ds_cnt + 1;
        else ds_cnt <= 0;
        if ((m_wr || m_rd) && !m_wait)
            mon_log.push_back(xfer_t'{m_wr, m_rd, m_addr, m_wd, m_be});
    end

    always @(negedge clk) begin
        if (m_wr) wr_cyc <= wr_cyc + 1;
        if (m_rd) rd_cyc <= rd_cyc + 1;
        if (m_wr && m_rd) proto_bad <= 1'b1;
    end

    task automatic drive(input int p, input logic wr, input logic rd,
                         input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        if (p == 0) begin
            s0_wr = wr; s0_rd = rd; s0_addr = a; s0_wd = d; s0_be = be;
        end else begin
            s1_wr = wr; s1_rd = rd; s1_addr = a; s1_wd = d; s1_be = be;
        end
    endtask

    // Avalon master behaviour: hold until waitrequest low, then drop.
    task automatic req_xfer(input int p, input logic wr, input logic rd,
                            input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int lat,
                            output logic [31:0] rdata, output logic g,
                            output logic w_after);
        lat = -1; rdata = '0; g = 1'b0; w_after = 1'b0;
        drive(p, wr, rd, a, d, be);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if ((p == 0 ? s0_wait : s1_wait) == 1'b0) begin
                lat = i;
                rdata = (p == 0) ? s0_rdata : s1_rdata;
                g = gid;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            w_after = (p == 0) ? s0_wait : s1_wait;
        end
        drive(p, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({s0_wait, s1_wait} !== 2'b11) begin errors++;
            $display("FAIL reset_wait got %b exp 11", {s0_wait, s1_wait}); end
        checks++; if (s0_rdata !== 32'h0 || s1_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_rdata got %h/%h exp 0", s0_rdata, s1_rdata); end
        checks++; if ({m_wr, m_rd} !== 2'b00) begin errors++;
            $display("FAIL reset_cmd got %b exp 00", {m_wr, m_rd}); end
        checks++; if ({m_addr, m_wd, m_be} !== 44'h0) begin errors++;
            $display("FAIL reset_mbus got %h exp 0", {m_addr, m_wd, m_be}); end
        checks++; if ({terr, gid} !== 2'b00) begin errors++;
            $display("FAIL reset_flags got %b exp 00", {terr, gid}); end
    endtask

    task automatic test_read();
        int lat; logic [31:0] r; logic g, w; int rc;
        ds_lat = 3;
        ds_mem[8'h04] = 32'h1234_5678;
        rc = rd_cyc;
        req_xfer(0, 1'b0, 1'b1, 8'h04, 32'h0, 4'hF, lat, r, g, w);
        checks++; if (lat != 5) begin errors++;
            $display("FAIL read_lat got %0d exp 5", lat); end
        checks++; if (r !== 32'h1234_5678) begin errors++;
            $display("FAIL read_data got %h exp 12345678", r); end
        checks++; if (g !== 1'b0 || w !== 1'b1) begin errors++;
            $display("FAIL read_gid_wait got %b%b exp 01", g, w); end
        checks++; if (rd_cyc - rc != 4) begin errors++;
            $display("FAIL read_cmd_cycles got %0d exp 4", rd_cyc - rc); end
    endtask

    task automatic test_tie();
        int l0, l1; logic [31:0] r0, r1; logic g0, g1, w0, w1; int n0;
        ds_lat = 1;
        for (int rnd = 0; rnd < 2; rnd++) begin
            n0 = mon_log.size();
            fork
                req_xfer(0, 1'b1, 1'b0, 8'h10, 32'hA5A5_A5A5, 4'hF,
                         l0, r0, g0, w0);
                req_xfer(1, 1'b1, 1'b0, 8'h20, 32'h5A5A_5A5A, 4'hF,
                         l1, r1, g1, w1);
            join
            checks++;
            if ((rnd == 0 && (l0 != 3 || l1 != 7)) ||
                (rnd == 1 && (l1 != 3 || l0 != 7))) begin errors++;
                $display("FAIL tie%0d_lat got s0=%0d s1=%0d", rnd, l0, l1); end
            checks++; if ({g0, g1, w0, w1} !== 4'b0111) begin errors++;
                $display("FAIL tie%0d_gid_wait got %b exp 0111",
                         rnd, {g0, g1, w0, w1}); end
            checks++; if (r0 !== 32'h0 || r1 !== 32'h0) begin errors++;
                $display("FAIL tie%0d_rdata got %h/%h exp 0", rnd, r0, r1); end
            checks++;
            if (mon_log.size() != n0 + 2) begin errors++;
                $display("FAIL tie%0d_count got %0d exp 2",
                         rnd, mon_log.size() - n0); end
            else if (mon_log[n0].a !== (rnd == 0 ? 8'h10 : 8'h20) ||
                     mon_log[n0 + 1].a !== (rnd == 0 ? 8'h20 : 8'h10) ||
                     mon_log[n0].wr !== 1'b1) begin errors++;
                $display("FAIL tie%0d_order got %h,%h", rnd,
                         mon_log[n0].a, mon_log[n0 + 1].a); end
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] r; logic g, w; int rc, wc;
        ds_lat = -1;
        rc = rd_cyc;
        req_xfer(1, 1'b0, 1'b1, 8'h33, 32'h0, 4'hF, lat, r, g, w);
        checks++; if (lat != 17) begin errors++;
            $display("FAIL tmo_lat got %0d exp 17", lat); end
        checks++; if (r !== 32'hDEAD_0000 || g !== 1'b1) begin errors++;
            $display("FAIL tmo_data got %h g%b exp dead0000 g1", r, g); end
        checks++; if (rd_cyc - rc != 16) begin errors++;
            $display("FAIL tmo_cmd_cycles got %0d exp 16", rd_cyc - rc); end
        checks++; if (terr !== 1'b1) begin errors++;
            $display("FAIL tmo_err got %b exp 1", terr); end
        ds_lat = 0;
        wc = wr_cyc;
        req_xfer(0, 1'b1, 1'b0, 8'h44, 32'hCAFE_F00D, 4'h3, lat, r, g, w);
        checks++; if (lat != 2 || r !== 32'h0 || w !== 1'b1) begin errors++;
            $display("FAIL tmo_next got lat%0d %h w%b exp lat2 0 w1",
                     lat, r, w); end
        checks++; if (terr !== 1'b1) begin errors++;
            $display("FAIL tmo_sticky got %b exp 1", terr); end
        checks++; if (wr_cyc - wc != 1) begin errors++;
            $display("FAIL tmo_next_wr got %0d exp 1", wr_cyc - wc); end
    endtask

    task automatic test_zero_wait();
        int lat; logic [31:0] r; logic g, w; int wc; int n0;
        ds_lat = 0;
        wc = wr_cyc;
        n0 = mon_log.size();
        req_xfer(0, 1'b1, 1'b0, 8'h7E, 32'h0BAD_BEEF, 4'h9, lat, r, g, w);
        checks++; if (lat != 2 || g !== 1'b0) begin errors++;
            $display("FAIL zw_lat got %0d g%b exp 2 g0", lat, g); end
        checks++; if (wr_cyc - wc != 1) begin errors++;
            $display("FAIL zw_wr_cycles got %0d exp 1", wr_cyc - wc); end
        checks++;
        if (mon_log.size() != n0 + 1 ||
            mon_log[n0] !== xfer_t'{1'b1, 1'b0, 8'h7E, 32'h0BAD_BEEF, 4'h9})
        begin errors++;
            $display("FAIL zw_bus got n%0d", mon_log.size() - n0); end
    endtask

    task automatic test_wr_rd();
        int lat; logic [31:0] r; logic g, w; int rc, wc; int n0;
        ds_lat = 1;
        ds_mem[8'h55] = 32'hFFFF_FFFF;
        rc = rd_cyc; wc = wr_cyc;
        n0 = mon_log.size();
        req_xfer(0, 1'b1, 1'b1, 8'h55, 32'h1357_9BDF, 4'h5, lat, r, g, w);
        checks++; if (lat != 3 || r !== 32'h0) begin errors++;
            $display("FAIL wrrd_resp got lat%0d %h exp lat3 0", lat, r); end
        checks++; if (rd_cyc - rc != 0 || wr_cyc - wc != 2) begin errors++;
            $display("FAIL wrrd_cmd got rd%0d wr%0d exp rd0 wr2",
                     rd_cyc - rc, wr_cyc - wc); end
        checks++;
        if (mon_log.size() != n0 + 1 ||
            mon_log[n0] !== xfer_t'{1'b1, 1'b0, 8'h55, 32'h1357_9BDF, 4'h5})
        begin errors++;
            $display("FAIL wrrd_bus got n%0d", mon_log.size() - n0); end
    endtask

    task automatic test_reset_busy();
        int lat; logic [31:0] r; logic g, w; int bad; int n0;
        ds_lat = -1;
        drive(0, 1'b1, 1'b0, 8'h66, 32'h1111_2222, 4'hF);
        @(negedge clk);
        checks++; if (m_wr !== 1'b1) begin errors++;
            $display("FAIL rb_busy got %b exp 1", m_wr); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({m_wr, s0_wait, gid, terr} !== 4'b0100) begin errors++;
            $display("FAIL rb_reset got %b exp 0100",
                     {m_wr, s0_wait, gid, terr}); end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (s0_wait !== 1'b1 || m_wr !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL rb_no_done got %0d bad cycles exp 0", bad); end
        ds_lat = 2;
        n0 = mon_log.size();
        req_xfer(0, 1'b1, 1'b0, 8'h67, 32'h3333_4444, 4'hC, lat, r, g, w);
        checks++;
        if (lat != 4 || g !== 1'b0 || mon_log.size() != n0 + 1 ||
            mon_log[n0] !== xfer_t'{1'b1, 1'b0, 8'h67, 32'h3333_4444, 4'hC})
        begin errors++;
            $display("FAIL rb_next got lat%0d g%b n%0d exp lat4 g0 n1",
                     lat, g, mon_log.size() - n0); end
    endtask

    // Model: fixed-latency device; ties alternate starting with s0,
    // the loser is served right after the winner's DONE/IDLE cycles.
    task automatic test_random();
        int prio, L, mode, c, n0, nexp;
        logic wr[2], rd[2];
        logic [7:0] a[2];
        logic [31:0] d[2];
        logic [3:0] be[2];
        int lat_o[2];
        logic [31:0] r_o[2];
        logic g_o[2], w_o[2];
        int exp_lat[2];
        int order[2];
        logic [31:0] exp_r;
        xfer_t e;
        do_reset();
        prio = 0;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(3, 1));
            L = int'($urandom_range(4, 0));
            ds_lat = L;
            for (int p = 0; p < 2; p++) begin
                c = int'($urandom_range(2, 0));
                wr[p] = (c != 0);
                rd[p] = (c != 1);
                a[p] = 8'($urandom);
                d[p] = $urandom;
                be[p] = 4'($urandom);
                exp_lat[p] = 0;
                order[p] = p;
            end
            if (mode == 3) begin
                nexp = 2;
                order[0] = prio;
                order[1] = 1 - prio;
                exp_lat[prio] = 2 + L;
                exp_lat[1 - prio] = 5 + 2 * L;
                prio = 1 - prio;
            end else begin
                nexp = 1;
                order[0] = mode - 1;
                exp_lat[mode - 1] = 2 + L;
            end
            n0 = mon_log.size();
            fork
                begin
                    if (mode != 2)
                        req_xfer(0, wr[0], rd[0], a[0], d[0], be[0],
                                 lat_o[0], r_o[0], g_o[0], w_o[0]);
                end
                begin
                    if (mode != 1)
                        req_xfer(1, wr[1], rd[1], a[1], d[1], be[1],
                                 lat_o[1], r_o[1], g_o[1], w_o[1]);
                end
            join
            for (int p = 0; p < 2; p++) begin
                if (mode == 3 || mode == p + 1) begin
                    exp_r = wr[p] ? 32'h0 : ds_mem[a[p]];
                    checks++;
                    if (lat_o[p] != exp_lat[p] || r_o[p] !== exp_r ||
                        g_o[p] !== 1'(p) || w_o[p] !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd%0d_s%0d got lat%0d %h g%b w%b exp lat%0d %h",
                                 it, p, lat_o[p], r_o[p], g_o[p], w_o[p],
                                 exp_lat[p], exp_r);
                    end
                end
            end
            checks++;
            if (mon_log.size() != n0 + nexp) begin errors++;
                $display("FAIL rnd%0d_count got %0d exp %0d",
                         it, mon_log.size() - n0, nexp); end
            else begin
                for (int k = 0; k < nexp; k++) begin
                    e = xfer_t'{wr[order[k]], rd[order[k]] & ~wr[order[k]],
                                a[order[k]], d[order[k]], be[order[k]]};
                    checks++;
                    if (mon_log[n0 + k] !== e) begin errors++;
                        $display("FAIL rnd%0d_bus%0d got %h exp %h",
                                 it, k, mon_log[n0 + k], e); end
                end
            end
            repeat (int'($urandom_range(2, 0))) @(negedge clk);
        end
        checks++; if (terr !== 1'b0) begin errors++;
            $display("FAIL rnd_terr got %b exp 0", terr); end
    endtask

    task automatic test_protocol();
        checks++; if (proto_bad !== 1'b0) begin errors++;
            $display("FAIL proto_wr_rd_both got %b exp 0", proto_bad); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ds_mem[8'(i)] = $urandom;
        test_reset();
        test_tie();
        test_read();
        test_timeout();
        test_zero_wait();
        test_wr_rd();
        test_reset_busy();
        test_random();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/qsys_serial_arbiter.md
QSYS_SERIAL_ARBITER -- requirements
Module: qsys_serial_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16'd1024: maximum BUSY cycles before a downstream transfer is abandoned.
REQ-002 The block SHALL have these ports, in this order:
- csi_MCLK_clk  in  1  single clock for all logic.
- rsi_MRST_reset  in  1  reset; synchronous to csi_MCLK_clk, active-high.
- avs_s0_address  in  8  requester 0 register address.
- avs_s0_writedata  in  32  requester 0 write data.
- avs_s0_byteenable  in  4  requester 0 byte enables.
- avs_s0_write / avs_s0_read  in  1 each  requester 0 commands.
- avs_s0_readdata  out  32  requester 0 read data.
- avs_s0_waitrequest  out  1  requester 0 stall.
- avs_s1_*  (same set, same widths)  requester 1.
- avm_m0_address  out  8  downstream serial device address.
- avm_m0_writedata  out  32  downstream write data.
- avm_m0_byteenable  out  4  downstream byte enables.
- avm_m0_write / avm_m0_read  out  1 each  downstream commands.
- avm_m0_readdata  in  32  downstream read data, valid in the cycle avm_m0_waitrequest is low.
- avm_m0_waitrequest  in  1  downstream stall.
- timeout_err  out  1  sticky flag: a downstream transfer timed out.
- grant_id  out  1  requester owning the current or last transfer.

Function
REQ-003 The FSM SHALL have states IDLE, BUSY, DONE; all outputs SHALL be registered.
REQ-004 In IDLE, a request (read or write high) from exactly one requester SHALL grant that requester.
REQ-005 If both requesters request in the same IDLE cycle, the grant SHALL go to the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-006 On grant, at the next edge, the block SHALL:
- latch address, writedata and byteenable from the granted port;
- assert avm_m0_write or avm_m0_read to match the requester's command;
- set grant_id;
- enter BUSY;
- clear the timeout counter.
REQ-007 If a requester asserts write and read together, the block SHALL treat the request as a write.
REQ-008 In BUSY, the master command SHALL be held stable until avm_m0_waitrequest is sampled low.
REQ-009 When avm_m0_waitrequest is sampled low in BUSY, at that edge the block SHALL:
- capture avm_m0_readdata (reads only);
- deassert the master command;
- enter DONE.
REQ-010 The BUSY timeout counter SHALL increment each BUSY cycle.
REQ-011 When the timeout counter reaches TIMEOUT-1 with avm_m0_waitrequest still high, at that edge the block SHALL:
- deassert the master command;
- load readdata 32'hDEAD_0000;
- set timeout_err;
- enter DONE.
REQ-012 In DONE, for exactly one cycle, the block SHALL:
- drive the granted port's waitrequest low;
- drive the granted port's readdata with the captured data (writes return 32'h0).
REQ-013 The FSM SHALL return from DONE to IDLE unconditionally.
REQ-014 Total latency SHALL be: grant edge + downstream wait + 1 DONE cycle. The minimum is request-sampled cycle t, DONE at t+2.
REQ-015 A port's waitrequest SHALL be high in every cycle except its own DONE cycle. This includes idle cycles, so requests are never accepted combinationally.
REQ-016 The non-granted requester SHALL see waitrequest high throughout and be served from the next IDLE; its request SHALL NOT be lost.
REQ-017 The block SHALL ignore requester signal changes while in BUSY or DONE.
REQ-018 A requester dropping its command during BUSY SHALL NOT abort the downstream transfer.
REQ-019 timeout_err SHALL be cleared only by reset.
REQ-020 A new transfer after a timeout SHALL proceed normally.
REQ-021 The block SHALL never assert avm_m0_write and avm_m0_read together.
REQ-022 The block SHALL never assert a master command outside BUSY.

Reset
REQ-023 With rsi_MRST_reset sampled high, at that edge the block SHALL:
- enter IDLE;
- clear avm_m0_write and avm_m0_read;
- drive avm_m0_address, avm_m0_writedata and avm_m0_byteenable to 0;
- set both avs waitrequests to 1;
- set both readdata outputs to 0;
- clear timeout_err;
- set grant_id to 0;
- clear the timeout counter;
- set the round-robin pointer so requester 0 wins the next tie.
REQ-024 A reset mid-BUSY SHALL drop the master command at the reset edge. The abandoned requester SHALL receive no DONE cycle.

Verification
REQ-025 s0 read addr 8'h04; downstream waitrequest low 3 cycles after command with readdata 32'h1234_5678 -> s0 waitrequest low for exactly one cycle, avs_s0_readdata=32'h1234_5678, grant_id=0.
REQ-026 s0 and s1 both write in the same cycle (8'h10/32'hA5A5_A5A5 and 8'h20/32'h5A5A_5A5A) immediately after reset -> s0 served first, then s1. Repeat the tie -> s1 first.
REQ-027 s1 read; downstream holds waitrequest high forever; TIMEOUT=16 -> command drops after 16 BUSY cycles, avs_s1_readdata=32'hDEAD_0000, timeout_err=1 and stays 1 through a following successful s0 write.
REQ-028 Zero-wait downstream (waitrequest low) -> s0 DONE two cycles after request sampled; avm_m0_write high exactly one cycle.
REQ-029 Reset asserted in the 2nd BUSY cycle of an s0 write -> avm_m0_write low after reset edge, s0 waitrequest stays high, grant_id=0, the next request is served normally.
REQ-030 s0 asserts write and read together -> only avm_m0_write is asserted, and the response returns readdata 32'h0.
